// File: rtl/ls_mem_ctrl.sv
// Data-memory access sequencer behind the load/store buffer: one load or store
// in flight, fixed-latency reads returned over the CDB, single-cycle writes.
module ls_mem_ctrl #(
  parameter int          ROB_BITS = 4,
  parameter int          MEM_BITS = 12,
  parameter int          MEM_LAT  = 2,
  parameter logic [11:0] LW_OPC   = 12'h023,
  parameter logic [11:0] SW_OPC   = 12'h02B
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ROB_BITS:0]   in_roben,
  input  logic [11:0]         in_opcode,
  input  logic [31:0]         in_ea,
  input  logic [31:0]         in_wdata,
  output logic [MEM_BITS-1:0] mem_addr,
  output logic                mem_re,
  output logic                mem_we,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  output logic                cdb_req,
  input  logic                cdb_gnt,
  output logic [ROB_BITS:0]   cdb_roben,
  output logic [31:0]         cdb_val,
  output logic                st_done,
  output logic [ROB_BITS:0]   st_roben,
  output logic                illegal_op
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    CDB_HOLD = 3'd3,
    WR       = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                accept;
  logic [MEM_BITS-1:0] mem_addr_nxt;
  logic                mem_re_nxt, mem_we_nxt;
  logic [31:0]         mem_wdata_nxt;
  logic                cdb_req_nxt;
  logic [ROB_BITS:0]   cdb_roben_nxt;
  logic [31:0]         cdb_val_nxt;
  logic                st_done_nxt;
  logic [ROB_BITS:0]   st_roben_nxt;
  logic                illegal_op_nxt;

  // Upper effective-address bits are deliberately ignored (address wraps).
  logic unused_ea;
  assign unused_ea = ^in_ea[31:MEM_BITS];

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready && (in_roben != '0) && !flush;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    mem_addr_nxt   = mem_addr;
    mem_re_nxt     = 1'b0;
    mem_we_nxt     = 1'b0;
    mem_wdata_nxt  = mem_wdata;
    cdb_req_nxt    = cdb_req;
    cdb_roben_nxt  = cdb_roben;
    cdb_val_nxt    = cdb_val;
    st_done_nxt    = 1'b0;
    st_roben_nxt   = st_roben;
    illegal_op_nxt = 1'b0;

    case (state)
      IDLE: begin
        cdb_req_nxt = 1'b0;
        if (accept) begin
          if (in_opcode == LW_OPC) begin
            state_nxt     = RD_ISSUE;
            mem_re_nxt    = 1'b1;
            mem_addr_nxt  = in_ea[MEM_BITS-1:0];
            cdb_roben_nxt = in_roben;
          end else if (in_opcode == SW_OPC) begin
            state_nxt     = WR;
            mem_we_nxt    = 1'b1;
            mem_addr_nxt  = in_ea[MEM_BITS-1:0];
            mem_wdata_nxt = in_wdata;
            st_done_nxt   = 1'b1;
            st_roben_nxt  = in_roben;
          end else begin
            illegal_op_nxt = 1'b1;
          end
        end
      end

      RD_ISSUE: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (MEM_LAT == 1) begin
          // Single-cycle memory: data is already valid during the strobe cycle.
          state_nxt   = CDB_HOLD;
          cdb_val_nxt = mem_rdata;
          cdb_req_nxt = 1'b1;
        end else begin
          state_nxt = RD_WAIT;
          cnt_nxt   = 4'(MEM_LAT - 1);
        end
      end

      RD_WAIT: begin
        if (flush) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == 4'd1) begin
          state_nxt   = CDB_HOLD;
          cnt_nxt     = '0;
          cdb_val_nxt = mem_rdata;
          cdb_req_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end

      CDB_HOLD: begin
        // A grant coinciding with flush still counts: the broadcast happened.
        if (cdb_gnt || flush) begin
          state_nxt   = IDLE;
          cdb_req_nxt = 1'b0;
        end
      end

      WR: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt   = IDLE;
        cnt_nxt     = '0;
        cdb_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      cdb_req    <= 1'b0;
      cdb_roben  <= '0;
      cdb_val    <= '0;
      st_done    <= 1'b0;
      st_roben   <= '0;
      illegal_op <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_re     <= mem_re_nxt;
      mem_we     <= mem_we_nxt;
      mem_wdata  <= mem_wdata_nxt;
      cdb_req    <= cdb_req_nxt;
      cdb_roben  <= cdb_roben_nxt;
      cdb_val    <= cdb_val_nxt;
      st_done    <= st_done_nxt;
      st_roben   <= st_roben_nxt;
      illegal_op <= illegal_op_nxt;
    end
  end

endmodule

// File: tb/tb_ls_mem_ctrl.sv
// Directed table-driven bench for ls_mem_ctrl with a 2-cycle memory model.
module tb_ls_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_roben;
  logic [11:0] in_opcode;
  logic [31:0] in_ea;
  logic [31:0] in_wdata;
  logic [11:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        cdb_req;
  logic        cdb_gnt;
  logic [4:0]  cdb_roben;
  logic [31:0] cdb_val;
  logic        st_done;
  logic [4:0]  st_roben;
  logic        illegal_op;

  int checks = 0;
  int errors = 0;

  ls_mem_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_roben(in_roben),
    .in_opcode(in_opcode), .in_ea(in_ea), .in_wdata(in_wdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .cdb_roben(cdb_roben),
    .cdb_val(cdb_val), .st_done(st_done), .st_roben(st_roben),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Memory model: read data is valid only in the cycle after the mem_re cycle.
  logic [31:0] load_data;
  logic        re_d;
  always @(posedge clk) re_d <= mem_re;
  assign mem_rdata = re_d ? load_data : 32'hBAD0_BAD0;

  localparam int K_LD = 0, K_ST = 1, K_IL = 2, K_IG = 3;

  typedef struct {
    logic [11:0] opc;
    logic [4:0]  tag;
    logic [31:0] ea;
    logic [31:0] wd;
    logic [31:0] rd;
    int          gw;
    int          kind;
    logic [11:0] eaddr;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_op(input logic [11:0] opc, input logic [4:0] tag,
                          input logic [31:0] ea, input logic [31:0] wd);
    in_valid  = 1'b1;
    in_opcode = opc;
    in_roben  = tag;
    in_ea     = ea;
    in_wdata  = wd;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_re"},     64'(mem_re), 64'd0);
    check({tag, "_we"},     64'(mem_we), 64'd0);
    check({tag, "_req"},    64'(cdb_req), 64'd0);
    check({tag, "_std"},    64'(st_done), 64'd0);
    check({tag, "_ill"},    64'(illegal_op), 64'd0);
    check({tag, "_addr"},   64'(mem_addr), 64'd0);
    check({tag, "_wdata"},  64'(mem_wdata), 64'd0);
    check({tag, "_croben"}, 64'(cdb_roben), 64'd0);
    check({tag, "_cval"},   64'(cdb_val), 64'd0);
    check({tag, "_sroben"}, 64'(st_roben), 64'd0);
  endtask

  initial begin
    vecs[0] = '{12'h023, 5'd5,  32'h0000_0404, 32'h0,          32'hDEAD_BEEF, 0, K_LD, 12'h404};
    vecs[1] = '{12'h023, 5'd31, 32'hFFFF_F123, 32'h0,          32'h0BAD_F00D, 5, K_LD, 12'h123};
    vecs[2] = '{12'h02B, 5'd3,  32'h0000_1FFC, 32'h1234_5678,  32'h0,         0, K_ST, 12'hFFC};
    vecs[3] = '{12'h000, 5'd7,  32'h0000_0010, 32'h0,          32'h0,         0, K_IL, 12'h000};
    vecs[4] = '{12'h023, 5'd0,  32'h0000_0020, 32'h0,          32'h1111_1111, 0, K_IG, 12'h000};
    vecs[5] = '{12'h02B, 5'd9,  32'h0000_0000, 32'hA5A5_A5A5,  32'h0,         0, K_ST, 12'h000};
    vecs[6] = '{12'h024, 5'd2,  32'h0000_0030, 32'h0,          32'h0,         0, K_IL, 12'h000};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_roben = '0; in_opcode = '0;
    in_ea = '0; in_wdata = '0; cdb_gnt = 1'b0; load_data = '0;
    step();
    step();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check_all_zero("rst");
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 7; i++) begin
      load_data = vecs[i].rd;
      drive_op(vecs[i].opc, vecs[i].tag, vecs[i].ea, vecs[i].wd);
      case (vecs[i].kind)
        K_LD: begin
          check($sformatf("v%0d_re", i),    64'(mem_re), 64'd1);
          check($sformatf("v%0d_addr", i),  64'(mem_addr), 64'(vecs[i].eaddr));
          check($sformatf("v%0d_busy", i),  64'(in_ready), 64'd0);
          step();
          check($sformatf("v%0d_re_off", i), 64'(mem_re), 64'd0);
          check($sformatf("v%0d_req_early", i), 64'(cdb_req), 64'd0);
          step();
          for (int w = 0; w < vecs[i].gw; w++) begin
            check($sformatf("v%0d_stall_req%0d", i, w), 64'(cdb_req), 64'd1);
            check($sformatf("v%0d_stall_tag%0d", i, w), 64'(cdb_roben), 64'(vecs[i].tag));
            check($sformatf("v%0d_stall_val%0d", i, w), 64'(cdb_val), 64'(vecs[i].rd));
            check($sformatf("v%0d_stall_rdy%0d", i, w), 64'(in_ready), 64'd0);
            step();
          end
          check($sformatf("v%0d_req", i), 64'(cdb_req), 64'd1);
          check($sformatf("v%0d_tag", i), 64'(cdb_roben), 64'(vecs[i].tag));
          check($sformatf("v%0d_val", i), 64'(cdb_val), 64'(vecs[i].rd));
          cdb_gnt = 1'b1;
          step();
          cdb_gnt = 1'b0;
          check($sformatf("v%0d_req_drop", i), 64'(cdb_req), 64'd0);
          check($sformatf("v%0d_rdy", i), 64'(in_ready), 64'd1);
        end
        K_ST: begin
          check($sformatf("v%0d_we", i),     64'(mem_we), 64'd1);
          check($sformatf("v%0d_addr", i),   64'(mem_addr), 64'(vecs[i].eaddr));
          check($sformatf("v%0d_wdata", i),  64'(mem_wdata), 64'(vecs[i].wd));
          check($sformatf("v%0d_std", i),    64'(st_done), 64'd1);
          check($sformatf("v%0d_stag", i),   64'(st_roben), 64'(vecs[i].tag));
          check($sformatf("v%0d_re", i),     64'(mem_re), 64'd0);
          step();
          check($sformatf("v%0d_we_off", i), 64'(mem_we), 64'd0);
          check($sformatf("v%0d_std_off", i), 64'(st_done), 64'd0);
          check($sformatf("v%0d_rdy", i),    64'(in_ready), 64'd1);
        end
        K_IL: begin
          check($sformatf("v%0d_ill", i), 64'(illegal_op), 64'd1);
          check($sformatf("v%0d_re", i),  64'(mem_re), 64'd0);
          check($sformatf("v%0d_we", i),  64'(mem_we), 64'd0);
          check($sformatf("v%0d_rdy", i), 64'(in_ready), 64'd1);
          step();
          check($sformatf("v%0d_ill_off", i), 64'(illegal_op), 64'd0);
        end
        default: begin
          check($sformatf("v%0d_re", i),  64'(mem_re), 64'd0);
          check($sformatf("v%0d_we", i),  64'(mem_we), 64'd0);
          check($sformatf("v%0d_ill", i), 64'(illegal_op), 64'd0);
          check($sformatf("v%0d_rdy", i), 64'(in_ready), 64'd1);
          step();
          step();
          check($sformatf("v%0d_req", i), 64'(cdb_req), 64'd0);
        end
      endcase
      step();
    end

    // Flush while waiting on read data: the result must never reach the CDB.
    load_data = 32'hCAFE_0001;
    drive_op(12'h023, 5'd6, 32'h0000_0100, 32'h0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flrd_req", 64'(cdb_req), 64'd0);
    check("flrd_rdy", 64'(in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("flrd_late_req%0d", k), 64'(cdb_req), 64'd0);
    end

    // Flush while the store is writing: the write still completes.
    drive_op(12'h02B, 5'd4, 32'h0000_0ABC, 32'h5555_AAAA);
    flush = 1'b1;
    check("flwr_we", 64'(mem_we), 64'd1);
    check("flwr_std", 64'(st_done), 64'd1);
    check("flwr_stag", 64'(st_roben), 64'd4);
    check("flwr_addr", 64'(mem_addr), 64'h0ABC);
    step();
    flush = 1'b0;
    check("flwr_we_off", 64'(mem_we), 64'd0);
    check("flwr_rdy", 64'(in_ready), 64'd1);

    // Valid op coinciding with flush is not accepted.
    flush = 1'b1;
    drive_op(12'h023, 5'd8, 32'h0000_0200, 32'h0);
    flush = 1'b0;
    check("flin_re", 64'(mem_re), 64'd0);
    check("flin_rdy", 64'(in_ready), 64'd1);
    step();
    step();
    check("flin_req", 64'(cdb_req), 64'd0);

    // Flush while holding the CDB request drops it the next cycle.
    load_data = 32'h7777_0000;
    drive_op(12'h023, 5'd10, 32'h0000_0300, 32'h0);
    step();
    step();
    check("flhold_req", 64'(cdb_req), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flhold_req_off", 64'(cdb_req), 64'd0);
    check("flhold_rdy", 64'(in_ready), 64'd1);

    // Reset asserted for two cycles in the middle of RD_WAIT.
    load_data = 32'h4444_4444;
    drive_op(12'h023, 5'd12, 32'h0000_0444, 32'h0);
    step();
    rst = 1'b1;
    step();
    check_all_zero("rstw1");
    step();
    rst = 1'b0;
    #1;
    check_all_zero("rstw2");
    check("rstw_rdy", 64'(in_ready), 64'd1);
    step();
    step();
    check("rstw_late_req", 64'(cdb_req), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
